// File: rtl/mram_axi_pkg.sv
// Shared response codes, FSM state encodings and counter width for the MRAM AXI responder.
package mram_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int LAT_CNT_W = 16;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_WAIT,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_LAT,
        R_DATA
    } rd_state_t;

endpackage

// File: rtl/mram_word_array.sv
// Non-volatile word store: one synchronous write port, one synchronous read port, no reset.
module mram_word_array #(
    parameter int WORDS = 1024,
    parameter int WIDTH = 64,
    parameter int IDX_W = $clog2(WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [IDX_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [WORDS];

    // A read and write to the same word on one edge returns the old contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/mram_axi_slave_model.sv
// AXI INCR-burst responder in front of the MRAM word array, with independent write and read FSMs.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high; valid/payload hold until then.
module mram_axi_slave_model
    import mram_axi_pkg::*;
#(
    parameter int                        AXI_ID_WIDTH   = 4,
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter int                        AXI_DATA_WIDTH = 64,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                        MEM_WORDS      = 1024,
    parameter int                        WR_LAT         = 4,
    parameter int                        RD_LAT         = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [AXI_ID_WIDTH-1:0]   awid,
    input  logic [AXI_ADDR_WIDTH-1:0] awaddr,
    input  logic [7:0]                awlen,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [AXI_DATA_WIDTH-1:0] wdata,
    input  logic                      wlast,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [AXI_ID_WIDTH-1:0]   bid,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    input  logic [AXI_ID_WIDTH-1:0]   arid,
    input  logic [AXI_ADDR_WIDTH-1:0] araddr,
    input  logic [7:0]                arlen,
    input  logic                      arvalid,
    output logic                      arready,
    output logic [AXI_ID_WIDTH-1:0]   rid,
    output logic [AXI_DATA_WIDTH-1:0] rdata,
    output logic [1:0]                rresp,
    output logic                      rvalid,
    output logic                      rlast,
    input  logic                      rready
);

    localparam int IDX_W   = $clog2(MEM_WORDS);
    localparam int BYTE_SH = $clog2(AXI_DATA_WIDTH / 8);
    localparam logic [LAT_CNT_W-1:0] WR_CNT_END = LAT_CNT_W'(WR_LAT - 1);
    localparam logic [LAT_CNT_W-1:0] RD_CNT_END = LAT_CNT_W'(RD_LAT - 1);

    // Whole burst must sit inside the window; computed one bit wider so idx+len cannot wrap.
    function automatic logic in_window(input logic [AXI_ADDR_WIDTH-1:0] addr,
                                       input logic [7:0] len);
        logic [AXI_ADDR_WIDTH:0] last_idx;
        last_idx = {1'b0, (addr - BASE_ADDR) >> BYTE_SH} + (AXI_ADDR_WIDTH+1)'(len);
        return (addr >= BASE_ADDR) && (last_idx < (AXI_ADDR_WIDTH+1)'(MEM_WORDS));
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [AXI_ADDR_WIDTH-1:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> BYTE_SH);
    endfunction

    // ---------------- write side ----------------
    wr_state_t                 wr_state, wr_next;
    logic [AXI_ID_WIDTH-1:0]   w_id_q;
    logic [IDX_W-1:0]          w_idx_q;
    logic [7:0]                w_len_q, w_beat_q;
    logic                      w_ok_q, w_err_q;
    logic [LAT_CNT_W-1:0]      w_cnt_q;
    logic                      aw_hs, w_hs, b_hs, w_last_beat;
    logic                      awready_d, wready_d, bvalid_d;
    logic [AXI_ID_WIDTH-1:0]   bid_d;
    logic [1:0]                bresp_d;

    assign aw_hs       = awvalid & awready;
    assign w_hs        = wvalid & wready;
    assign b_hs        = bvalid & bready;
    assign w_last_beat = (w_beat_q == w_len_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state <= W_IDLE;
        end else begin
            wr_state <= wr_next;
        end
    end

    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            W_IDLE:  if (aw_hs) wr_next = W_DATA;
            W_DATA:  if (w_hs && w_last_beat) wr_next = W_WAIT;
            W_WAIT:  if (w_cnt_q == WR_CNT_END) wr_next = W_RESP;
            W_RESP:  if (b_hs) wr_next = W_IDLE;
            default: wr_next = W_IDLE;
        endcase
    end

    always_comb begin
        awready_d = (wr_next == W_IDLE);
        wready_d  = (wr_next == W_DATA);
        bvalid_d  = (wr_next == W_RESP);
        bid_d     = bid;
        bresp_d   = bresp;
        if (wr_state == W_WAIT && wr_next == W_RESP) begin
            bid_d   = w_id_q;
            bresp_d = !w_ok_q ? RESP_DECERR : (w_err_q ? RESP_SLVERR : RESP_OKAY);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b0;
            bid      <= '0;
            bresp    <= RESP_OKAY;
            w_id_q   <= '0;
            w_idx_q  <= '0;
            w_len_q  <= '0;
            w_beat_q <= '0;
            w_ok_q   <= 1'b0;
            w_err_q  <= 1'b0;
            w_cnt_q  <= '0;
        end else begin
            awready <= awready_d;
            wready  <= wready_d;
            bvalid  <= bvalid_d;
            bid     <= bid_d;
            bresp   <= bresp_d;
            w_cnt_q <= (wr_state == W_WAIT) ? w_cnt_q + LAT_CNT_W'(1) : '0;
            if (aw_hs) begin
                w_id_q   <= awid;
                w_idx_q  <= word_idx(awaddr);
                w_len_q  <= awlen;
                w_ok_q   <= in_window(awaddr, awlen);
                w_beat_q <= '0;
                w_err_q  <= 1'b0;
            end
            // Burst length is governed by awlen; a misplaced wlast only flags SLVERR.
            if (w_hs) begin
                w_beat_q <= w_beat_q + 8'd1;
                if (wlast != w_last_beat) begin
                    w_err_q <= 1'b1;
                end
            end
        end
    end

    // ---------------- read side ----------------
    rd_state_t                 rd_state, rd_next;
    logic [AXI_ID_WIDTH-1:0]   r_id_q;
    logic [IDX_W-1:0]          r_idx_q;
    logic [7:0]                r_len_q, r_beat_q, r_off;
    logic                      r_ok_q;
    logic [LAT_CNT_W-1:0]      r_cnt_q;
    logic                      ar_hs, r_hs, r_last_beat, r_lat_done;
    logic                      arready_d, rvalid_d, rlast_d;
    logic [AXI_ID_WIDTH-1:0]   rid_d;
    logic [1:0]                rresp_d;
    logic                      mem_re;
    logic [IDX_W-1:0]          mem_raddr;
    logic [AXI_DATA_WIDTH-1:0] mem_rdata;

    assign ar_hs       = arvalid & arready;
    assign r_hs        = rvalid & rready;
    assign r_last_beat = (r_beat_q == r_len_q);
    assign r_lat_done  = (r_cnt_q == RD_CNT_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state <= R_IDLE;
        end else begin
            rd_state <= rd_next;
        end
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            R_IDLE:  if (ar_hs) rd_next = R_LAT;
            R_LAT:   if (r_lat_done) rd_next = R_DATA;
            R_DATA:  if (r_hs && r_last_beat) rd_next = R_IDLE;
            default: rd_next = R_IDLE;
        endcase
    end

    always_comb begin
        arready_d = (rd_next == R_IDLE);
        rvalid_d  = (rd_next == R_DATA);
        rlast_d   = rlast;
        rid_d     = rid;
        rresp_d   = rresp;
        if (rd_state == R_LAT && rd_next == R_DATA) begin
            rlast_d = (r_len_q == 8'd0);
            rid_d   = r_id_q;
            rresp_d = r_ok_q ? RESP_OKAY : RESP_DECERR;
        end else if (rd_state == R_DATA && r_hs) begin
            rlast_d = !r_last_beat && (r_beat_q + 8'd1 == r_len_q);
        end
    end

    // The array fetch for a beat happens on the same edge that presents it, so back-to-back beats need no bubble.
    assign r_off     = (rd_state == R_DATA) ? r_beat_q + 8'd1 : 8'd0;
    assign mem_raddr = r_idx_q + IDX_W'(r_off);
    assign mem_re    = r_ok_q && ((rd_state == R_LAT && r_lat_done) ||
                                  (rd_state == R_DATA && r_hs && !r_last_beat));
    assign rdata     = r_ok_q ? mem_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arready  <= 1'b0;
            rvalid   <= 1'b0;
            rlast    <= 1'b0;
            rid      <= '0;
            rresp    <= RESP_OKAY;
            r_id_q   <= '0;
            r_idx_q  <= '0;
            r_len_q  <= '0;
            r_beat_q <= '0;
            r_ok_q   <= 1'b0;
            r_cnt_q  <= '0;
        end else begin
            arready <= arready_d;
            rvalid  <= rvalid_d;
            rlast   <= rlast_d;
            rid     <= rid_d;
            rresp   <= rresp_d;
            r_cnt_q <= (rd_state == R_LAT) ? r_cnt_q + LAT_CNT_W'(1) : '0;
            if (ar_hs) begin
                r_id_q   <= arid;
                r_idx_q  <= word_idx(araddr);
                r_len_q  <= arlen;
                r_ok_q   <= in_window(araddr, arlen);
                r_beat_q <= '0;
            end
            if (r_hs && !r_last_beat) begin
                r_beat_q <= r_beat_q + 8'd1;
            end
        end
    end

    mram_word_array #(
        .WORDS (MEM_WORDS),
        .WIDTH (AXI_DATA_WIDTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (w_hs & w_ok_q),
        .waddr (w_idx_q + IDX_W'(w_beat_q)),
        .wdata (wdata),
        .re    (mem_re),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_mram_axi_slave_model.sv
// Directed plus randomized bench for mram_axi_slave_model against a word-indexed memory model.
module tb_mram_axi_slave_model;

    localparam int MW     = 1024;
    localparam int WR_LAT = 4;
    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  awid, arid, bid, rid;
    logic [31:0] awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rlast, rready;
    logic [63:0] wdata, rdata;
    logic [1:0]  bresp, rresp;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [63:0] mm [int];
    logic [63:0] exp_q [$];

    mram_axi_slave_model #(
        .AXI_ID_WIDTH(4), .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64),
        .BASE_ADDR(32'h0), .MEM_WORDS(MW), .WR_LAT(WR_LAT), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rlast(rlast), .rready(rready)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    function automatic bit win_ok(input logic [31:0] addr, input int len);
        longint idx;
        idx = longint'(addr) / 8;
        return (idx + len) < MW;
    endfunction

    function automatic int idx_of(input logic [31:0] addr);
        return int'(addr / 8);
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_awready"}, 64'(awready), 64'(0));
        chk({tag, "_wready"},  64'(wready),  64'(0));
        chk({tag, "_arready"}, 64'(arready), 64'(0));
        chk({tag, "_bvalid"},  64'(bvalid),  64'(0));
        chk({tag, "_rvalid"},  64'(rvalid),  64'(0));
        chk({tag, "_rlast"},   64'(rlast),   64'(0));
        chk({tag, "_bid"},     64'(bid),     64'(0));
        chk({tag, "_bresp"},   64'(bresp),   64'(0));
        chk({tag, "_rid"},     64'(rid),     64'(0));
        chk({tag, "_rresp"},   64'(rresp),   64'(0));
        chk({tag, "_rdata"},   rdata,        64'(0));
    endtask

    // ---------------- driver tasks (enter and leave just after a falling edge) ----------------
    task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input int len);
        int t = 0;
        awid = id; awaddr = addr; awlen = 8'(len); awvalid = 1'b1;
        while (!awready && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) chk("aw_timeout", 64'(0), 64'(1));
        @(negedge clk);
        awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [63:0] d, input bit last);
        int t = 0;
        wdata = d; wlast = last; wvalid = 1'b1;
        while (!wready && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) chk("w_timeout", 64'(0), 64'(1));
        @(negedge clk);
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                               input int bad_beat, input bit fixed_pat);
        bit ok, mism, wl;
        int idx, t, e_w, gap;
        logic [63:0] d;
        logic [1:0] er;
        ok = win_ok(addr, len); idx = idx_of(addr); mism = 1'b0;
        aw_send(id, addr, len);
        for (int b = 0; b <= len; b++) begin
            if (fixed_pat) begin
                d = {32'hC0DE0000 + 32'(b), 32'hA5A50000 + 32'(b)};
            end else begin
                d = {$urandom, $urandom};
                if ($urandom_range(0, 3) == 0) @(negedge clk);
            end
            wl = (b == len) || (b == bad_beat);
            if (wl != (b == len)) mism = 1'b1;
            w_send(d, wl);
            if (ok) mm[idx + b] = d;
        end
        e_w = cyc;
        t = 0;
        while (!bvalid && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) chk("b_timeout", 64'(0), 64'(1));
        er = !ok ? 2'b11 : (mism ? 2'b10 : 2'b00);
        chk("b_latency", 64'(cyc - e_w), 64'(WR_LAT));
        chk("b_id", 64'(bid), 64'(id));
        chk("b_resp", 64'(bresp), 64'(er));
        gap = int'($urandom_range(0, 2));
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            chk("b_hold", 64'(bvalid), 64'(1));
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk("b_drop", 64'(bvalid), 64'(0));
        chk("aw_rearm", 64'(awready), 64'(1));
    endtask

    // mode 0: rready held high; 1: rready pattern 1,0,0,1; 2: random rready
    task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                              input int mode);
        bit ok, first, stalled, rr;
        int idx, beat, k, t, e_ar;
        logic [63:0] hold_d, e;
        logic hold_l;
        ok = win_ok(addr, len); idx = idx_of(addr);
        for (int b = 0; b <= len; b++) exp_q.push_back(ok ? mm[idx + b] : 64'd0);
        arid = id; araddr = addr; arlen = 8'(len); arvalid = 1'b1;
        t = 0;
        while (!arready && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) chk("ar_timeout", 64'(0), 64'(1));
        @(negedge clk);
        arvalid = 1'b0;
        e_ar = cyc;
        beat = 0; k = 0; first = 1'b1; stalled = 1'b0; t = 0;
        hold_d = '0; hold_l = 1'b0;
        while (beat <= len && t < 500) begin
            case (mode)
                0:       rr = 1'b1;
                1:       rr = (k % 4 == 0) || (k % 4 == 3);
                default: rr = 1'($urandom_range(0, 1));
            endcase
            rready = rr;
            if (rvalid) begin
                if (first) begin
                    chk("r_latency", 64'(cyc - e_ar), 64'(RD_LAT));
                    first = 1'b0;
                end
                if (stalled) begin
                    chk("r_hold_data", rdata, hold_d);
                    chk("r_hold_last", 64'(rlast), 64'(hold_l));
                end
                if (rr) begin
                    e = exp_q.pop_front();
                    chk("r_data", rdata, e);
                    chk("r_last", 64'(rlast), 64'(beat == len));
                    chk("r_resp", 64'(rresp), ok ? 64'(0) : 64'(3));
                    chk("r_id", 64'(rid), 64'(id));
                    beat++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    hold_d = rdata;
                    hold_l = rlast;
                end
                k++;
            end
            @(negedge clk);
            t++;
        end
        rready = 1'b0;
        if (beat <= len) begin
            chk("r_timeout", 64'(0), 64'(1));
            exp_q.delete();
        end
        chk("r_done_valid", 64'(rvalid), 64'(0));
        chk("ar_rearm", 64'(arready), 64'(1));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [63:0] old_d, d;
        int ridx, rlen, t;
        logic [31:0] raddr;

        rst_n = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
        wdata = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_awready", 64'(awready), 64'(1));
        chk("post_rst_arready", 64'(arready), 64'(1));

        // Fixed-pattern 4-beat write and read-back
        write_burst(4'd1, 32'h1000, 3, -1, 1'b1);
        read_burst(4'd1, 32'h1000, 3, 0);
        // Same data with rready stalls
        read_burst(4'd2, 32'h1000, 3, 1);

        // Window edge: seed last two words, then an overrunning burst must be rejected
        write_burst(4'd6, 32'h1FF0, 1, -1, 1'b0);
        write_burst(4'd7, 32'h1FF0, 3, -1, 1'b0);
        read_burst(4'd7, 32'h1FF0, 3, 0);
        read_burst(4'd8, 32'h1FF0, 1, 0);

        // Early wlast: burst still runs to awlen, flagged SLVERR, data kept
        write_burst(4'd4, 32'h1100, 3, 1, 1'b0);
        read_burst(4'd4, 32'h1100, 3, 2);

        // Collision: a presented R beat keeps its data while the same word is rewritten
        write_burst(4'd9, 32'h1008, 0, -1, 1'b0);
        old_d = mm[32'h1008 / 8];
        arid = 4'd2; araddr = 32'h1008; arlen = 8'd0; arvalid = 1'b1; rready = 1'b0;
        t = 0;
        while (!arready && t < 200) begin @(negedge clk); t++; end
        @(negedge clk);
        arvalid = 1'b0;
        t = 0;
        while (!rvalid && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) chk("coll_r_timeout", 64'(0), 64'(1));
        write_burst(4'd3, 32'h1008, 0, -1, 1'b0);
        chk("coll_old_data", rdata, old_d);
        chk("coll_old_last", 64'(rlast), 64'(1));
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        chk("coll_done", 64'(rvalid), 64'(0));
        read_burst(4'd2, 32'h1008, 0, 0);

        // Randomized in-window bursts with ignored low address bits
        for (int i = 0; i < 6; i++) begin
            ridx = int'($urandom_range(32'h320, 32'h3F0));
            rlen = int'($urandom_range(0, 7));
            raddr = 32'(ridx * 8) + 32'($urandom_range(0, 7));
            write_burst(4'($urandom_range(0, 15)), raddr, rlen, -1, 1'b0);
            read_burst(4'($urandom_range(0, 15)), raddr, rlen, 2);
        end

        // Randomized overrun burst
        ridx = int'($urandom_range(MW - 8, MW - 1));
        rlen = MW - ridx + int'($urandom_range(0, 3));
        write_burst(4'd5, 32'(ridx * 8), rlen, -1, 1'b0);
        read_burst(4'd5, 32'(ridx * 8), rlen, 2);

        // Reset in the middle of a write burst after two committed beats
        aw_send(4'd10, 32'h1800, 3);
        for (int b = 0; b < 2; b++) begin
            d = {$urandom, $urandom};
            w_send(d, 1'b0);
            mm[32'h1800 / 8 + b] = d;
        end
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_awready", 64'(awready), 64'(1));
        chk("midrst_arready", 64'(arready), 64'(1));
        for (int c = 0; c < WR_LAT + 3; c++) begin
            @(negedge clk);
            chk("midrst_no_b", 64'(bvalid), 64'(0));
        end
        read_burst(4'd11, 32'h1800, 1, 0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
